// File: rtl/dfswt_iq_frame_if.sv
// Sample-in / frame-result-out bundle for the IQ square-wave integrator.
interface dfswt_iq_frame_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] datain;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  result_i;
  logic signed [ACC_W-1:0]  result_q;
  logic                     overrun;

  modport master (output in_valid, datain, out_ready,
                  input  out_valid, result_i, result_q, overrun);
  modport slave  (input  in_valid, datain, out_ready,
                  output out_valid, result_i, result_q, overrun);
endinterface

// File: rtl/dfswt_iq_frame.sv
// Frame integrator correlating samples against cosine/sine square waves.
// One lane per quadrature component; the top owns frame count and result handshake.
module dfswt_iq_lane #(
  parameter int                 ACC_W   = 32,
  parameter int                 COUNT_W = 3,
  parameter int                 STEP    = 1,
  parameter logic [COUNT_W-1:0] PH0     = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             restart,
  input  logic             adv,
  input  logic             last,
  input  logic [ACC_W-1:0] dext,
  output logic [ACC_W-1:0] sum_nxt
);
  logic [ACC_W-1:0]   acc;
  logic [COUNT_W-1:0] ph;

  // sign comes from the phase before this edge's increment
  assign sum_nxt = ph[COUNT_W-1] ? acc - dext : acc + dext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
      ph  <= PH0;
    end else if (restart || (adv && last)) begin
      acc <= '0;
      ph  <= PH0;
    end else if (adv) begin
      acc <= sum_nxt;
      ph  <= ph + COUNT_W'(STEP);
    end
  end
endmodule

module dfswt_iq_frame #(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int POINTS    = 8,
  parameter int COUNT_W   = 3,
  parameter int STEP      = 1,
  parameter int FRAME_LEN = 8
) (
  input logic              clock,
  input logic              reset,
  input logic              restart,
  dfswt_iq_frame_if.slave  s
);
  localparam int NUM_LANES = 2;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  logic [CNT_W-1:0]                 cnt;
  logic [ACC_W-1:0]                 dext;
  logic [NUM_LANES-1:0][ACC_W-1:0]  lane_sum;
  logic                             adv, last, load, drop;

  assign dext = {{(ACC_W-DATA_W){s.datain[DATA_W-1]}}, s.datain};
  assign adv  = s.in_valid & ~restart;
  assign last = adv && (cnt == CNT_W'(FRAME_LEN-1));
  assign load = last && (!s.out_valid || s.out_ready);
  assign drop = last && s.out_valid && !s.out_ready;

  // lane 0 is in-phase (cosine, starts a quarter period in), lane 1 quadrature
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dfswt_iq_lane #(
      .ACC_W  (ACC_W),
      .COUNT_W(COUNT_W),
      .STEP   (STEP),
      .PH0    (COUNT_W'(l == 0 ? POINTS/4 : 0))
    ) u_lane (
      .clock  (clock),
      .reset  (reset),
      .restart(restart),
      .adv    (adv),
      .last   (last),
      .dext   (dext),
      .sum_nxt(lane_sum[l])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   cnt <= '0;
    else if (restart || last)    cnt <= '0;
    else if (adv)                cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s.out_valid <= 1'b0;
      s.result_i  <= '0;
      s.result_q  <= '0;
    end else if (load) begin
      s.out_valid <= 1'b1;
      s.result_i  <= lane_sum[0];
      s.result_q  <= lane_sum[1];
    end else if (s.out_ready) begin
      s.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        s.overrun <= 1'b0;
    else if (restart) s.overrun <= 1'b0;
    else if (drop)    s.overrun <= 1'b1;
  end
endmodule

// File: tb/tb_dfswt_iq_frame.sv
// Randomized bench for dfswt_iq_frame against a square-wave correlation model.
module tb_dfswt_iq_frame;
  localparam int DATA_W = 16, ACC_W = 32, POINTS = 8, COUNT_W = 3, FRAME_LEN = 8;
  typedef int frame_t [FRAME_LEN];

  logic clock = 1'b0;
  logic reset, restart, restart2;
  int   n_cmp = 0, n_bad = 0;

  always #5 clock = ~clock;

  dfswt_iq_frame_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();
  dfswt_iq_frame_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus2 ();

  dfswt_iq_frame #(.DATA_W(DATA_W), .ACC_W(ACC_W), .POINTS(POINTS), .COUNT_W(COUNT_W),
                   .STEP(1), .FRAME_LEN(FRAME_LEN))
    u_dut (.clock(clock), .reset(reset), .restart(restart), .s(bus));

  dfswt_iq_frame #(.DATA_W(DATA_W), .ACC_W(ACC_W), .POINTS(POINTS), .COUNT_W(COUNT_W),
                   .STEP(2), .FRAME_LEN(FRAME_LEN))
    u_dut2 (.clock(clock), .reset(reset), .restart(restart2), .s(bus2));

  // Frame sum of d against a square wave of the given period offset and step
  function automatic logic signed [ACC_W-1:0] ref_sum(input frame_t d, input int step, input bit q);
    longint acc = 0;
    int ph;
    for (int k = 0; k < FRAME_LEN; k++) begin
      ph = ((q ? 0 : POINTS/4) + k*step) % POINTS;
      acc += (ph < POINTS/2) ? longint'(d[k]) : -longint'(d[k]);
    end
    return acc[ACC_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic send(input bit which, input int v);
    if (which) begin bus2.in_valid = 1'b1; bus2.datain = DATA_W'(v); end
    else       begin bus.in_valid  = 1'b1; bus.datain  = DATA_W'(v); end
    tick();
    bus.in_valid = 1'b0; bus2.in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit which, input frame_t d);
    for (int k = 0; k < FRAME_LEN; k++) send(which, d[k]);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
  endtask

  function automatic frame_t rand_frame();
    frame_t d;
    for (int k = 0; k < FRAME_LEN; k++) d[k] = int'($urandom_range(65535)) - 32768;
    return d;
  endfunction

  task automatic test_reset();
    reset = 1'b1; #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.result_i !== '0) begin n_bad++; $display("FAIL reset_result_i got %0d want 0", bus.result_i); end
    n_cmp++; if (bus.result_q !== '0) begin n_bad++; $display("FAIL reset_result_q got %0d want 0", bus.result_q); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_constant();
    frame_t d;
    for (int k = 0; k < FRAME_LEN; k++) d[k] = 100;
    for (int k = 0; k < FRAME_LEN-1; k++) send(0, d[k]);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL const_early_valid got %b want 0", bus.out_valid); end
    send(0, d[FRAME_LEN-1]);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL const_latency got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.result_i !== ref_sum(d, 1, 0)) begin n_bad++; $display("FAIL const_i got %0d want %0d", bus.result_i, ref_sum(d, 1, 0)); end
    n_cmp++; if (bus.result_q !== ref_sum(d, 1, 1)) begin n_bad++; $display("FAIL const_q got %0d want %0d", bus.result_q, ref_sum(d, 1, 1)); end
    consume();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL const_consumed got %b want 0", bus.out_valid); end
  endtask

  task automatic test_step_reversal();
    frame_t d;
    for (int k = 0; k < FRAME_LEN; k++) d[k] = (k < 4) ? 100 : -100;
    send_frame(0, d);
    n_cmp++; if (bus.result_i !== ref_sum(d, 1, 0)) begin n_bad++; $display("FAIL rev_i got %0d want %0d", bus.result_i, ref_sum(d, 1, 0)); end
    n_cmp++; if (bus.result_q !== ref_sum(d, 1, 1)) begin n_bad++; $display("FAIL rev_q got %0d want %0d", bus.result_q, ref_sum(d, 1, 1)); end
    consume();
    n_cmp++; if (bus.result_q !== ref_sum(d, 1, 1)) begin n_bad++; $display("FAIL rev_hold got %0d want %0d", bus.result_q, ref_sum(d, 1, 1)); end
  endtask

  task automatic test_impulse();
    frame_t d;
    for (int k = 0; k < FRAME_LEN; k++) d[k] = (k == 2) ? 50 : 0;
    send_frame(0, d);
    n_cmp++; if (bus.result_i !== ref_sum(d, 1, 0)) begin n_bad++; $display("FAIL imp_i got %0d want %0d", bus.result_i, ref_sum(d, 1, 0)); end
    n_cmp++; if (bus.result_q !== ref_sum(d, 1, 1)) begin n_bad++; $display("FAIL imp_q got %0d want %0d", bus.result_q, ref_sum(d, 1, 1)); end
    consume();
  endtask

  task automatic test_random();
    frame_t d;
    for (int f = 0; f < 6; f++) begin
      d = rand_frame();
      for (int k = 0; k < FRAME_LEN; k++) begin
        repeat ($urandom_range(2)) tick();
        send(0, d[k]);
      end
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_valid got %b want 1", f, bus.out_valid); end
      n_cmp++; if (bus.result_i !== ref_sum(d, 1, 0)) begin n_bad++; $display("FAIL rnd%0d_i got %0d want %0d", f, bus.result_i, ref_sum(d, 1, 0)); end
      n_cmp++; if (bus.result_q !== ref_sum(d, 1, 1)) begin n_bad++; $display("FAIL rnd%0d_q got %0d want %0d", f, bus.result_q, ref_sum(d, 1, 1)); end
      repeat ($urandom_range(2)) tick();
      consume();
    end
  endtask

  task automatic test_overrun();
    frame_t a, b, c;
    a = rand_frame(); b = rand_frame(); c = rand_frame();
    send_frame(0, a);
    send_frame(0, b);
    n_cmp++; if (bus.overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %b want 1", bus.overrun); end
    n_cmp++; if (bus.result_i !== ref_sum(a, 1, 0)) begin n_bad++; $display("FAIL ovr_hold_i got %0d want %0d", bus.result_i, ref_sum(a, 1, 0)); end
    n_cmp++; if (bus.result_q !== ref_sum(a, 1, 1)) begin n_bad++; $display("FAIL ovr_hold_q got %0d want %0d", bus.result_q, ref_sum(a, 1, 1)); end
    // restart with a sample on the same edge: the sample must not count
    send(0, 3);
    restart = 1'b1; bus.in_valid = 1'b1; bus.datain = 16'sd1000;
    tick();
    restart = 1'b0; bus.in_valid = 1'b0;
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear got %b want 0", bus.overrun); end
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid_kept got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.result_i !== ref_sum(a, 1, 0)) begin n_bad++; $display("FAIL ovr_restart_i got %0d want %0d", bus.result_i, ref_sum(a, 1, 0)); end
    tick();
    consume();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_consume got %b want 0", bus.out_valid); end
    send_frame(0, c);
    n_cmp++; if (bus.result_i !== ref_sum(c, 1, 0)) begin n_bad++; $display("FAIL post_restart_i got %0d want %0d", bus.result_i, ref_sum(c, 1, 0)); end
    n_cmp++; if (bus.result_q !== ref_sum(c, 1, 1)) begin n_bad++; $display("FAIL post_restart_q got %0d want %0d", bus.result_q, ref_sum(c, 1, 1)); end
  endtask

  task automatic test_reset_mid();
    frame_t d;
    // result from the previous task is still held when reset hits
    for (int k = 0; k < 5; k++) send(0, 77);
    #2 reset = 1'b1; #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.result_i !== '0 || bus.result_q !== '0) begin n_bad++; $display("FAIL rmid_result got %0d/%0d want 0/0", bus.result_i, bus.result_q); end
    @(negedge clock); reset = 1'b0;
    tick();
    for (int k = 0; k < FRAME_LEN; k++) d[k] = (k < 4) ? 100 : -100;
    send_frame(0, d);
    n_cmp++; if (bus.result_q !== ref_sum(d, 1, 1)) begin n_bad++; $display("FAIL rmid_q got %0d want %0d", bus.result_q, ref_sum(d, 1, 1)); end
    n_cmp++; if (bus.result_i !== ref_sum(d, 1, 0)) begin n_bad++; $display("FAIL rmid_i got %0d want %0d", bus.result_i, ref_sum(d, 1, 0)); end
  endtask

  task automatic test_back_to_back();
    frame_t y;
    y = rand_frame();
    // previous frame is still held; consume only on the completion edge of y
    for (int k = 0; k < FRAME_LEN-1; k++) send(0, y[k]);
    bus.out_ready = 1'b1;
    send(0, y[FRAME_LEN-1]);
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun got %b want 0", bus.overrun); end
    n_cmp++; if (bus.result_i !== ref_sum(y, 1, 0)) begin n_bad++; $display("FAIL b2b_i got %0d want %0d", bus.result_i, ref_sum(y, 1, 0)); end
    n_cmp++; if (bus.result_q !== ref_sum(y, 1, 1)) begin n_bad++; $display("FAIL b2b_q got %0d want %0d", bus.result_q, ref_sum(y, 1, 1)); end
    consume();
  endtask

  task automatic test_step2();
    frame_t d;
    for (int k = 0; k < FRAME_LEN; k++) d[k] = 100;
    send_frame(1, d);
    n_cmp++; if (bus2.out_valid !== 1'b1) begin n_bad++; $display("FAIL s2_valid got %b want 1", bus2.out_valid); end
    n_cmp++; if (bus2.result_i !== ref_sum(d, 2, 0)) begin n_bad++; $display("FAIL s2_const_i got %0d want %0d", bus2.result_i, ref_sum(d, 2, 0)); end
    n_cmp++; if (bus2.result_q !== ref_sum(d, 2, 1)) begin n_bad++; $display("FAIL s2_const_q got %0d want %0d", bus2.result_q, ref_sum(d, 2, 1)); end
    bus2.out_ready = 1'b1; tick(); bus2.out_ready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      d = rand_frame();
      send_frame(1, d);
      n_cmp++; if (bus2.result_i !== ref_sum(d, 2, 0)) begin n_bad++; $display("FAIL s2_rnd%0d_i got %0d want %0d", f, bus2.result_i, ref_sum(d, 2, 0)); end
      n_cmp++; if (bus2.result_q !== ref_sum(d, 2, 1)) begin n_bad++; $display("FAIL s2_rnd%0d_q got %0d want %0d", f, bus2.result_q, ref_sum(d, 2, 1)); end
      bus2.out_ready = 1'b1; tick(); bus2.out_ready = 1'b0;
    end
  endtask

  initial begin
    restart = 1'b0; restart2 = 1'b0;
    bus.in_valid = 1'b0;  bus.datain = '0;  bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.datain = '0; bus2.out_ready = 1'b0;
    test_reset();
    test_constant();
    test_step_reversal();
    test_impulse();
    test_random();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_step2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dfswt_iq_frame.md
DFSWT_IQ_FRAME -- requirements
Module: dfswt_iq_frame

Interface
REQ-001 Parameter DATA_W, default 16, signed input sample width.
REQ-002 Parameter ACC_W, default 32, signed accumulator and result width; ACC_W SHALL be at least DATA_W + log2(FRAME_LEN) + 1.
REQ-003 Parameter POINTS, default 8, square-wave period in phase units; SHALL be a power of two, at least 4.
REQ-004 Parameter COUNT_W, default 3, phase counter width, equal to log2(POINTS).
REQ-005 Parameter STEP, default 1, phase increment per accepted sample, in the range 1..POINTS/2.
REQ-006 Parameter FRAME_LEN, default 8, samples per integration frame, at least 2.
REQ-007 clock  input  1  rising-edge clock; only clock domain.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 restart  input  1  synchronous frame abort and restart.
REQ-010 in_valid  input  1  datain is accepted on this edge; no input backpressure.
REQ-011 datain  input  DATA_W  signed sample.
REQ-012 out_valid  output  1  result registers hold an unconsumed frame result.
REQ-013 out_ready  input  1  consumer accepts the result when out_valid is high.
REQ-014 result_i  output  ACC_W  signed in-phase (cosine square wave) frame sum.
REQ-015 result_q  output  ACC_W  signed quadrature (sine square wave) frame sum.
REQ-016 overrun  output  1  sticky flag: a completed frame was dropped.

Function
REQ-017 Phase counters ph_i and ph_q are COUNT_W bits wide; frame start loads ph_i=POINTS/4 and ph_q=0.
REQ-018 On each in_valid (restart low), both counters advance by STEP, modulo POINTS, with natural wrap.
REQ-019 Sign rule: a counter MSB of 0 adds datain to its accumulator; an MSB of 1 subtracts it. The sign uses the counter value before that edge's increment.
REQ-020 datain is sign-extended to ACC_W; the accumulators wrap in two's complement with no saturation.
REQ-021 Sample counter counts 0..FRAME_LEN-1 on accepted samples.
REQ-022 Frame complete: the accepted sample at count FRAME_LEN-1. At that edge the completed sums, including this sample, go to the result path, and the accumulators, phase counters and sample counter reload frame-start values.
REQ-023 Result load occurs on frame complete when out_valid is 0, or when out_valid and out_ready are both 1 on the same edge. In these cases result_i and result_q update and out_valid is 1 next cycle.
REQ-024 On frame complete with out_valid high and out_ready low, the new result is dropped, the held result is unchanged, and overrun is set.
REQ-025 out_valid clears on out_ready when no frame completes on the same edge; result_i and result_q hold their value after consumption.
REQ-026 Latency: out_valid is high on the cycle after the edge that accepts the last sample of the frame.
REQ-027 restart high: clears accumulators, sample counter and overrun, and reloads the phase counters; in_valid on the same edge is discarded. The output handshake (out_valid, result_*) is unaffected.
REQ-028 in_valid low: no state change except the output handshake.
REQ-029 Result contents depend only on the data within their frame; no inter-frame carry.

Reset
REQ-030 Asynchronous assertion of reset drives out_valid=0, overrun=0, result_i=0, result_q=0, accumulators=0, sample counter=0, ph_i=POINTS/4 and ph_q=0 immediately.
REQ-031 Reset mid-frame discards partial sums; the first accepted sample after release is sample 0 of a new frame.
REQ-032 Reset deassertion is treated as synchronous to clock by the integrator; the block needs no internal synchronizer.

Verification (defaults: POINTS=8, STEP=1, FRAME_LEN=8)
REQ-033 Eight samples of +100 -> result_i=0, result_q=0, out_valid high one cycle after the 8th sample.
REQ-034 Four samples of +100 then four of -100 -> result_i=0, result_q=+800.
REQ-035 Impulse +50 at sample index 2, other samples 0 -> result_i=-50, result_q=+50.
REQ-036 Two back-to-back frames with out_ready held low -> first result held, overrun=1 after the second frame. Raising restart then clears overrun, and out_valid stays 1 until out_ready.
REQ-037 Reset asserted after sample 5 (no clock edge required) -> all outputs 0 immediately. A following 8-sample +100/-100 frame -> result_q=+800.
REQ-038 out_ready pulsed on the exact edge of the next frame completion -> new result loaded, out_valid stays 1, overrun stays 0. Also run STEP=2: eight samples of +100 -> result_i=0, result_q=0.
